// File: rtl/gate_bus_pkg.sv
// Shared definitions for the gated-bus reduction blocks: mode encodings and
// legal parameter ranges.
package gate_bus_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_OR   = 2'b00;
  localparam logic [MODE_W-1:0] MODE_AND  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_XOR  = 2'b10;
  localparam logic [MODE_W-1:0] MODE_RSVD = 2'b11;

  localparam int unsigned MIN_BITS   = 1;
  localparam int unsigned MAX_BITS   = 32;
  localparam int unsigned MIN_INPUTS = 2;
  localparam int unsigned MAX_INPUTS = 16;

endpackage

// File: rtl/gate_bus_reduce_core.sv
// Purely combinational N-input bitwise reduction (OR / AND / XOR) selected by
// a 2-bit mode; the reserved mode yields zero. Reusable by other gated-bus blocks.
module gate_bus_reduce_core
  import gate_bus_pkg::*;
#(
  parameter int unsigned NrOfBits   = 8,
  parameter int unsigned NrOfInputs = 5
) (
  input  logic [NrOfInputs*NrOfBits-1:0] buses,
  input  logic [MODE_W-1:0]              mode,
  output logic [NrOfBits-1:0]            result_c
);

  logic [NrOfBits-1:0] red_or;
  logic [NrOfBits-1:0] red_and;
  logic [NrOfBits-1:0] red_xor;

  // Fold every bus into the three candidate reductions.
  always_comb begin
    red_or  = '0;
    red_and = '1;
    red_xor = '0;
    for (int unsigned i = 0; i < NrOfInputs; i++) begin
      red_or  = red_or  | buses[i*NrOfBits +: NrOfBits];
      red_and = red_and & buses[i*NrOfBits +: NrOfBits];
      red_xor = red_xor ^ buses[i*NrOfBits +: NrOfBits];
    end
  end

  // Pick the reduction requested by the sample's mode.
  always_comb begin
    result_c = '0;
    case (mode)
      MODE_OR:  result_c = red_or;
      MODE_AND: result_c = red_and;
      MODE_XOR: result_c = red_xor;
      default:  result_c = '0;
    endcase
  end

endmodule

// File: rtl/gate_bus_reduce_pipe.sv
// Two-stage valid/ready gated bus reduction. Stage 1 captures the bubbled
// inputs with their mode; stage 2 registers the reduction.
// Optional feature macro: REDUCE_GATE_ACCUM_EN adds an OR-accumulator of
// handshaken results (acc_clear / acc_result ports).
module gate_bus_reduce_pipe
  import gate_bus_pkg::*;
#(
  parameter int unsigned           NrOfBits    = 8,
  parameter int unsigned           NrOfInputs  = 5,
  parameter logic [NrOfInputs-1:0] BubblesMask = '0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NrOfInputs*NrOfBits-1:0] inputs,
  input  logic [MODE_W-1:0]              mode,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [NrOfBits-1:0]            result,
  output logic                           out_valid,
`ifdef REDUCE_GATE_ACCUM_EN
  input  logic                           acc_clear,
  output logic [NrOfBits-1:0]            acc_result,
`endif
  input  logic                           out_ready
);

  localparam int unsigned BUS_W = NrOfInputs * NrOfBits;

  logic                advance;
  logic [BUS_W-1:0]    bubble_bus;
  logic [BUS_W-1:0]    s1_bus;
  logic [MODE_W-1:0]   s1_mode;
  logic                s1_valid;
  logic [NrOfBits-1:0] reduced_c;

  // Whole pipe moves together; it stalls only when a held result is refused.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Expand the per-input bubble bit across that input's full bus width.
  always_comb begin
    bubble_bus = '0;
    for (int unsigned i = 0; i < NrOfInputs; i++) begin
      bubble_bus[i*NrOfBits +: NrOfBits] = {NrOfBits{BubblesMask[i]}};
    end
  end

  // Stage 1: capture inverted-as-needed buses together with their mode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_bus   <= '0;
      s1_mode  <= MODE_OR;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_bus  <= inputs ^ bubble_bus;
        s1_mode <= mode;
      end
    end
  end

  gate_bus_reduce_core #(
    .NrOfBits   (NrOfBits),
    .NrOfInputs (NrOfInputs)
  ) u_core (
    .buses    (s1_bus),
    .mode     (s1_mode),
    .result_c (reduced_c)
  );

  // Stage 2: register the reduction; an empty stage 1 clocks a bubble through.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= reduced_c;
      end
    end
  end

`ifdef REDUCE_GATE_ACCUM_EN
  logic handshake;

  assign handshake = out_valid && out_ready;

  // Accumulate handshaken results; a clear with a handshake restarts from it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_result <= '0;
    end else if (acc_clear && handshake) begin
      acc_result <= result;
    end else if (acc_clear) begin
      acc_result <= '0;
    end else if (handshake) begin
      acc_result <= acc_result | result;
    end
  end
`endif

endmodule

// File: doc/gate_bus_reduce_pipe.md
# gate_bus_reduce_pipe

Parametrised, pipelined successor to the fixed 5-input bus gates. It reduces NrOfInputs buses of NrOfBits each with a per-input bubble (inversion) mask and a per-sample, runtime-selected operation (OR/AND/XOR). Results come out through a 2-stage valid/ready pipeline. It sits between the datapath bus multiplexers and the Baby's accumulator/test logic, where wide gated reductions must be registered to close timing.

## Interface
Parameters:
- NrOfBits, 8, width of each input bus and of the result (1..32).
- NrOfInputs, 5, number of input buses (2..16).
- BubblesMask, 0, NrOfInputs-bit mask; bit i set inverts input i before reduction.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- inputs  in  NrOfInputs*NrOfBits  flattened buses; input i occupies bits [i*NrOfBits +: NrOfBits].
- mode  in  2  operation: 00 OR, 01 AND, 10 XOR, 11 reserved.
- in_valid  in  1  sample on inputs/mode is valid.
- in_ready  out  1  pipeline accepts a sample this cycle.
- result  out  NrOfBits  reduced value.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts result.
- acc_clear  in  1  clears accumulator (only with REDUCE_GATE_ACCUM_EN).
- acc_result  out  NrOfBits  accumulated value (only with REDUCE_GATE_ACCUM_EN).

## Operation
- Stage 1 (capture): on in_valid && in_ready, register each input XOR-ed with its BubblesMask bit (all NrOfBits bits inverted), plus mode, and set s1_valid.
- Stage 2 (reduce): register the bitwise reduction of the stage-1 buses using the stage-1 mode. 00 is OR over all inputs, 01 AND, 10 XOR (odd parity per bit), 11 forces result = 0. Stage 2 drives result/out_valid.
- Mode travels with its sample. Changing mode while samples are in flight affects only newly accepted samples.
- Advance rule: advance = !out_valid || out_ready; in_ready = advance. When advance = 0, both stages hold their contents and valid bits.
- A bubble is clocked through: when advance = 1 and s1_valid = 0, stage 2 loads out_valid = 0.
- in_valid while in_ready = 0 is ignored. The producer must hold its sample.
- Reset values: result = 0, out_valid = 0, in_ready = 1 (combinational from out_valid = 0), acc_result = 0, s1 state = 0.
- Reset mid-stream discards all in-flight samples. No output handshake follows.

## Timing
- Latency: 2 cycles from accept edge to out_valid high, when out_ready is held high.
- Throughput: 1 sample/cycle with out_ready held high.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from in_valid or inputs to any output.
- Stall: out_ready low with out_valid high freezes result and out_valid, and deasserts in_ready the same cycle.
- Maximum occupancy is 2 samples, one per stage. No skid buffer is used.

## Configuration
- REDUCE_GATE_ACCUM_EN defined: adds acc_clear and acc_result, plus an NrOfBits accumulator.
  - On each output handshake (out_valid && out_ready), acc <= acc | result.
  - acc_clear alone sets acc <= 0.
  - acc_clear together with a handshake sets acc <= result.
  - acc_result = acc (registered).
- Macro undefined: the ports and register are absent. Behaviour is otherwise identical.

## Structure
- Shared package gate_bus_pkg holds:
  - mode encoding constants MODE_OR = 2'b00, MODE_AND = 2'b01, MODE_XOR = 2'b10, MODE_RSVD = 2'b11;
  - NrOfBits/NrOfInputs limit constants.
- One sub-module, gate_bus_reduce_core: purely combinational N-input reduction with a mode input. It is instantiated between stage 1 and stage 2, and is reusable by other gated-bus blocks.

## Test plan
- NrOfInputs = 5, NrOfBits = 8, mask 0, mode OR, inputs 01,02,04,08,10 (hex), out_ready = 1 -> result 1F with out_valid high exactly 2 cycles after accept.
- Mask 5'b00001, mode AND, all inputs FF -> result 00. Mask 0, same inputs -> FF. Mode 11 -> 00.
- Back-to-back samples: OR, then AND, then XOR on inputs FF,0F,F0,00,00 -> results FF, 00, 00 in consecutive cycles. This proves mode travels with its sample.
- Hold out_ready low for 3 cycles with 2 samples in flight -> result frozen, in_ready low, no sample lost or duplicated. On release, both samples emerge in order.
- Assert reset asynchronously with 2 samples in flight -> out_valid, result and acc_result go to 0 before the next edge. No stale output appears after reset release.
- With REDUCE_GATE_ACCUM_EN: handshake results 01 then 80 -> acc_result 81. acc_clear coincident with handshake result 3C -> acc_result 3C.
